// File: rtl/camera_mode_sequencer_pkg.sv
// Shared types and constants for the camera/sobel mode-switch sequencer:
// FSM encoding, mode codes, frame sizes and the per-mode SCCB config words.
package camera_mode_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RST    = 3'd1,
      ST_SETTLE = 3'd2,
      ST_CFG    = 3'd3,
      ST_DONE   = 3'd4
   } seq_state_e;

   localparam logic MODE_CAM   = 1'b0;
   localparam logic MODE_SOBEL = 1'b1;

   localparam logic [10:0] H_CAM   = 11'd256;
   localparam logic [10:0] V_CAM   = 11'd208;
   localparam logic [10:0] H_SOBEL = 11'd800;
   localparam logic [10:0] V_SOBEL = 11'd600;

   localparam int unsigned CFG_WORDS = 2;
   localparam int unsigned IDX_W     = 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CFG_WORDS - 1);

   // Config words are {reg_addr, reg_val}.
   localparam logic [15:0] CFG_CAM_0   = 16'h5A40;
   localparam logic [15:0] CFG_CAM_1   = 16'h5B34;
   localparam logic [15:0] CFG_SOBEL_0 = 16'h5AC8;
   localparam logic [15:0] CFG_SOBEL_1 = 16'h5B96;

   function automatic logic [10:0] frame_h(input logic m);
      return (m == MODE_SOBEL) ? H_SOBEL : H_CAM;
   endfunction

   function automatic logic [10:0] frame_v(input logic m);
      return (m == MODE_SOBEL) ? V_SOBEL : V_CAM;
   endfunction

endpackage

// File: rtl/camera_mode_sequencer_cfg_rom.sv
// Combinational config-word lookup: (mode, word index) -> SCCB word.
module cam_mode_cfg_rom
   import camera_mode_sequencer_pkg::*;
(
   input  logic             i_mode,
   input  logic [IDX_W-1:0] i_idx,
   output logic [15:0]      o_data
);

   always_comb begin
      o_data = 16'h0000;
      case ({i_mode, i_idx})
         {MODE_CAM,   1'b0}: o_data = CFG_CAM_0;
         {MODE_CAM,   1'b1}: o_data = CFG_CAM_1;
         {MODE_SOBEL, 1'b0}: o_data = CFG_SOBEL_0;
         {MODE_SOBEL, 1'b1}: o_data = CFG_SOBEL_1;
         default:            o_data = 16'h0000;
      endcase
   end

endmodule

// File: rtl/camera_mode_sequencer.sv
// Mode-switch sequencer: pulses camera reset, waits for the sensor to settle,
// then streams the new mode's config words to the SCCB master.
module camera_mode_sequencer
   import camera_mode_sequencer_pkg::*;
#(
   parameter logic [15:0] RST_CYC    = 16'd1000,
   parameter logic [15:0] SETTLE_CYC = 16'd20000
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        one_flag,
   input  logic        two_flag,
   input  logic        cfg_ack,
   output logic        camera_rstn,
   output logic        cfg_req,
   output logic [15:0] cfg_data,
   output logic        mode,
   output logic        busy,
   output logic [10:0] h_pixel,
   output logic [10:0] v_pixel,
   output seq_state_e  o_dbg_state
);

   // cfg handshake: a word is transferred on the rising edge where cfg_req
   // and cfg_ack are both high; cfg_data is held stable while cfg_req is high,
   // and cfg_ack seen while cfg_req is low has no effect.

   seq_state_e       r_state;
   logic             r_mode;
   logic             r_rstn;
   logic             r_cfg_req;
   logic [15:0]      r_cfg_data;
   logic             r_busy;
   logic [10:0]      r_h;
   logic [10:0]      r_v;
   logic             r_pend_valid;
   logic             r_pend_mode;
   logic [15:0]      r_cnt;
   logic [IDX_W-1:0] r_idx;

   logic        w_req_valid;
   logic        w_req_mode;
   logic        w_pend_valid;
   logic        w_pend_mode;
   logic        w_start;
   logic        w_start_mode;
   logic [16:0] w_cnt_next;
   logic        w_rst_term;
   logic        w_settle_term;
   logic [15:0] w_rom_data;

   // two_flag wins a same-cycle tie.
   assign w_req_valid = one_flag | two_flag;
   assign w_req_mode  = two_flag ? MODE_SOBEL : MODE_CAM;

   // A request landing in the DONE cycle itself overrides the latched one.
   assign w_pend_valid = w_req_valid | r_pend_valid;
   assign w_pend_mode  = w_req_valid ? w_req_mode : r_pend_mode;

   assign w_start = ((r_state == ST_IDLE) && w_req_valid  && (w_req_mode  != r_mode)) ||
                    ((r_state == ST_DONE) && w_pend_valid && (w_pend_mode != r_mode));
   assign w_start_mode = (r_state == ST_DONE) ? w_pend_mode : w_req_mode;

   // Terminal compare in 17 bits so a zero-length parameter cannot underflow.
   assign w_cnt_next    = {1'b0, r_cnt} + 17'd1;
   assign w_rst_term    = (w_cnt_next >= {1'b0, RST_CYC});
   assign w_settle_term = (w_cnt_next >= {1'b0, SETTLE_CYC});

   cam_mode_cfg_rom u_rom (
      .i_mode (r_mode),
      .i_idx  (r_idx),
      .o_data (w_rom_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_mode       <= MODE_CAM;
         r_rstn       <= 1'b1;
         r_cfg_req    <= 1'b0;
         r_cfg_data   <= 16'h0000;
         r_busy       <= 1'b0;
         r_h          <= H_CAM;
         r_v          <= V_CAM;
         r_pend_valid <= 1'b0;
         r_pend_mode  <= MODE_CAM;
         r_cnt        <= 16'd0;
         r_idx        <= '0;
      end else if (w_start) begin
         r_state      <= ST_RST;
         r_mode       <= w_start_mode;
         r_h          <= frame_h(w_start_mode);
         r_v          <= frame_v(w_start_mode);
         r_rstn       <= 1'b0;
         r_cfg_req    <= 1'b0;
         r_busy       <= 1'b1;
         r_pend_valid <= 1'b0;
         r_cnt        <= 16'd0;
         r_idx        <= '0;
      end else begin
         if ((r_state != ST_IDLE) && (r_state != ST_DONE) && w_req_valid) begin
            r_pend_valid <= 1'b1;
            r_pend_mode  <= w_req_mode;
         end
         case (r_state)
            ST_RST: begin
               if (w_rst_term) begin
                  r_state <= ST_SETTLE;
                  r_rstn  <= 1'b1;
                  r_cnt   <= 16'd0;
               end else begin
                  r_cnt <= w_cnt_next[15:0];
               end
            end
            ST_SETTLE: begin
               if (w_settle_term) begin
                  r_state    <= ST_CFG;
                  r_cnt      <= 16'd0;
                  r_cfg_req  <= 1'b1;
                  r_cfg_data <= w_rom_data;
               end else begin
                  r_cnt <= w_cnt_next[15:0];
               end
            end
            ST_CFG: begin
               if (r_cfg_req) begin
                  if (cfg_ack) begin
                     r_cfg_req <= 1'b0;
                     if (r_idx == LAST_IDX) begin
                        r_state <= ST_DONE;
                     end else begin
                        r_idx <= r_idx + 1'b1;
                     end
                  end
               end else begin
                  // One-cycle gap after each ack, then present the next word.
                  r_cfg_req  <= 1'b1;
                  r_cfg_data <= w_rom_data;
               end
            end
            ST_DONE: begin
               r_state      <= ST_IDLE;
               r_busy       <= 1'b0;
               r_pend_valid <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign camera_rstn = r_rstn;
   assign cfg_req     = r_cfg_req;
   assign cfg_data    = r_cfg_data;
   assign mode        = r_mode;
   assign busy        = r_busy;
   assign h_pixel     = r_h;
   assign v_pixel     = r_v;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_camera_mode_sequencer.sv
// Directed bench for camera_mode_sequencer with short reset/settle counts.
module tb_camera_mode_sequencer;
   import camera_mode_sequencer_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        one_flag;
   logic        two_flag;
   logic        cfg_ack;
   logic        camera_rstn;
   logic        cfg_req;
   logic [15:0] cfg_data;
   logic        mode;
   logic        busy;
   logic [10:0] h_pixel;
   logic [10:0] v_pixel;
   seq_state_e  dbg_state;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      int          n;
      logic        one;
      logic        two;
      logic        ack;
      logic        rstn;
      logic        req;
      logic        chk;
      logic [15:0] data;
      logic        md;
      logic        bz;
   } vec_t;

   localparam int NV = 14;
   vec_t tv[NV];

   camera_mode_sequencer #(
      .RST_CYC    (16'd4),
      .SETTLE_CYC (16'd8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .one_flag    (one_flag),
      .two_flag    (two_flag),
      .cfg_ack     (cfg_ack),
      .camera_rstn (camera_rstn),
      .cfg_req     (cfg_req),
      .cfg_data    (cfg_data),
      .mode        (mode),
      .busy        (busy),
      .h_pixel     (h_pixel),
      .v_pixel     (v_pixel),
      .o_dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input int n, input int one, input int two, input int ack,
                               input int rstn, input int req, input int chk,
                               input logic [15:0] data, input int md, input int bz);
      vec_t v;
      v.n = n;       v.one = one[0]; v.two = two[0]; v.ack = ack[0];
      v.rstn = rstn[0]; v.req = req[0]; v.chk = chk[0]; v.data = data;
      v.md = md[0];  v.bz = bz[0];
      return v;
   endfunction

   // Drive inputs, let one rising edge consume them, sample 1ns later.
   task automatic step(input logic one, input logic two, input logic ack);
      one_flag = one;
      two_flag = two;
      cfg_ack  = ack;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic e_rstn, input logic e_req,
                        input logic e_chk, input logic [15:0] e_data,
                        input logic e_md, input logic e_bz);
      logic [10:0] eh;
      logic [10:0] ev;
      eh = e_md ? 11'd800 : 11'd256;
      ev = e_md ? 11'd600 : 11'd208;
      n_vec++;
      if (camera_rstn !== e_rstn || cfg_req !== e_req || (e_chk && cfg_data !== e_data) ||
          mode !== e_md || busy !== e_bz || h_pixel !== eh || v_pixel !== ev) begin
         n_err++;
         $display("FAIL %s: got rstn=%b req=%b data=%h mode=%b busy=%b h=%0d v=%0d | exp rstn=%b req=%b data=%h(chk=%b) mode=%b busy=%b h=%0d v=%0d",
                  nm, camera_rstn, cfg_req, cfg_data, mode, busy, h_pixel, v_pixel,
                  e_rstn, e_req, e_data, e_chk, e_md, e_bz, eh, ev);
      end
   endtask

   task automatic wait_req(input logic [15:0] e_data, input string nm);
      int k;
      k = 0;
      while (cfg_req !== 1'b1 && k < 200) begin
         step(1'b0, 1'b0, 1'b0);
         k++;
      end
      n_vec++;
      if (cfg_req !== 1'b1 || cfg_data !== e_data) begin
         n_err++;
         $display("FAIL %s: got req=%b data=%h after %0d cycles, exp req=1 data=%h",
                  nm, cfg_req, cfg_data, k, e_data);
      end
   endtask

   initial begin
      //               n  one two ack rstn req chk data      md bz
      tv[0]  = mk(3,  0, 0, 0, 1, 0, 1, 16'h0000, 0, 0);
      tv[1]  = mk(1,  0, 1, 0, 0, 0, 1, 16'h0000, 1, 1);
      tv[2]  = mk(3,  0, 0, 0, 0, 0, 1, 16'h0000, 1, 1);
      tv[3]  = mk(8,  0, 0, 0, 1, 0, 1, 16'h0000, 1, 1);
      tv[4]  = mk(1,  0, 0, 0, 1, 1, 1, 16'h5AC8, 1, 1);
      tv[5]  = mk(50, 0, 0, 0, 1, 1, 1, 16'h5AC8, 1, 1);
      tv[6]  = mk(1,  0, 0, 1, 1, 0, 0, 16'h0000, 1, 1);
      tv[7]  = mk(1,  0, 0, 1, 1, 1, 1, 16'h5B96, 1, 1);
      tv[8]  = mk(1,  0, 0, 1, 1, 0, 0, 16'h0000, 1, 1);
      tv[9]  = mk(1,  0, 0, 0, 1, 0, 0, 16'h0000, 1, 0);
      tv[10] = mk(1,  1, 1, 0, 1, 0, 0, 16'h0000, 1, 0);
      tv[11] = mk(3,  0, 0, 0, 1, 0, 0, 16'h0000, 1, 0);
      tv[12] = mk(1,  0, 1, 0, 1, 0, 0, 16'h0000, 1, 0);
      tv[13] = mk(2,  0, 0, 1, 1, 0, 0, 16'h0000, 1, 0);

      rst_n    = 1'b0;
      one_flag = 1'b0;
      two_flag = 1'b0;
      cfg_ack  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset", 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Full 0->1 switch, long ack stall, stray acks, ignored same-mode requests.
      for (int i = 0; i < NV; i++) begin
         for (int c = 0; c < tv[i].n; c++) begin
            step(tv[i].one, tv[i].two, tv[i].ack);
            check($sformatf("vec%0d.%0d", i, c), tv[i].rstn, tv[i].req, tv[i].chk,
                  tv[i].data, tv[i].md, tv[i].bz);
         end
      end

      // Asynchronous reset in the middle of a 1->0 config phase.
      step(1'b1, 1'b0, 1'b0);
      check("m0_start", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
      wait_req(16'h5A40, "m0_word0");
      #2;
      rst_n = 1'b0;
      #1;
      check("midcfg_reset", 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step(1'b0, 1'b0, 1'b1);
         check($sformatf("post_reset.%0d", c), 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
      end

      // 0->1 switch with a mode-0 request latched during SETTLE.
      step(1'b0, 1'b1, 1'b0);
      check("m1_start", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      repeat (5) step(1'b0, 1'b0, 1'b0);
      check("in_settle", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      wait_req(16'h5AC8, "seqA_word0");
      step(1'b0, 1'b0, 1'b1);
      wait_req(16'h5B96, "seqA_word1");
      step(1'b0, 1'b0, 1'b1);
      check("seqA_done", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      check("seqB_start", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
      wait_req(16'h5A40, "seqB_word0");
      step(1'b0, 1'b0, 1'b1);
      wait_req(16'h5B34, "seqB_word1");
      step(1'b0, 1'b0, 1'b1);
      check("seqB_done", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      check("seqB_idle", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b0);
      check("final_idle", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/camera_mode_sequencer.md
CAMERA_MODE_SEQUENCER -- requirements
Module: camera_mode_sequencer

Interface
REQ-001 Parameter RST_CYC, default 16'd1000: cycles camera_rstn is held low per mode switch.
REQ-002 Parameter SETTLE_CYC, default 16'd20000: cycles waited after camera_rstn release before the first config write.
REQ-003 clk  input  1  sole clock; every flop is on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 one_flag  input  1  single-cycle request for mode 0 (camera pass-through, 256x208).
REQ-006 two_flag  input  1  single-cycle request for mode 1 (sobel, 800x600).
REQ-007 cfg_ack  input  1  SCCB master has accepted the current cfg_data word.
REQ-008 camera_rstn  output  1  active-low camera reset.
REQ-009 cfg_req  output  1  config-write request to the SCCB master.
REQ-010 cfg_data  output  16  config word {reg_addr[15:8], reg_val[7:0]}.
REQ-011 mode  output  1  active mode: 0 = camera, 1 = sobel.
REQ-012 busy  output  1  high while a switch sequence runs; downstream gates sdram_wren with it.
REQ-013 h_pixel, v_pixel  output  11 each  active frame size.

Function
REQ-014 FSM states: IDLE, RST, SETTLE, CFG, DONE.
REQ-015 IDLE: a request for a mode different from mode -> RST on the next edge; mode, h_pixel and v_pixel update on that same edge.
REQ-016 IDLE: a request equal to the current mode is ignored; no reset and no writes.
REQ-017 one_flag and two_flag in the same cycle: two_flag wins.
REQ-018 RST: camera_rstn = 0 for exactly RST_CYC cycles, then -> SETTLE with camera_rstn = 1.
REQ-019 SETTLE: count SETTLE_CYC cycles, then -> CFG with word index 0.
REQ-020 CFG: cfg_req = 1 with cfg_data stable until cfg_ack is sampled high.
REQ-021 CFG: on ack, cfg_req = 0 for at least one cycle, then the index increments.
REQ-022 CFG: after the ack of the last word -> DONE.
REQ-023 Config table, 2 words per mode: mode 0 = 16'h5A40, 16'h5B34; mode 1 = 16'h5AC8, 16'h5B96.
REQ-024 A cfg_ack while cfg_req = 0 is ignored.
REQ-025 DONE: one cycle, then -> IDLE.
REQ-026 busy = 1 in RST, SETTLE, CFG and DONE; busy = 0 in IDLE.
REQ-027 Requests arriving while busy are latched into a one-deep pending slot; the last request wins.
REQ-028 From DONE with a pending mode different from mode -> RST; otherwise the pending slot is cleared and the FSM returns to IDLE.
REQ-029 h_pixel/v_pixel = 256/208 in mode 0 and 800/600 in mode 1, registered.
REQ-030 Counters are 16-bit and never wrap: each stops at its terminal count.

Reset
REQ-031 rst_n low forces all state and outputs immediately, even mid-sequence: state = IDLE, mode = 0, camera_rstn = 1, cfg_req = 0, cfg_data = 16'h0000, busy = 0, h_pixel = 256, v_pixel = 208, pending slot empty, counters = 0.
REQ-032 After rst_n deasserts, the first request for mode 1 starts a full sequence; no write is issued implicitly.

Structure
REQ-033 A shared package holds: the state encoding, MODE_CAM/MODE_SOBEL constants, the frame-size constants (256, 208, 800, 600), the config-table words and CFG_WORDS = 2.
REQ-034 Sub-module cam_mode_cfg_rom is combinational: (mode, index) -> cfg_data.
REQ-035 No other sub-modules.

Verification (bench uses RST_CYC = 4, SETTLE_CYC = 8)
REQ-036 Reset, then a two_flag pulse at cycle 0 -> camera_rstn low cycles 1-4; cfg_req high at cycle 13 with 16'h5AC8; ack -> 16'h5B96; ack -> busy = 0; h/v = 800/600.
REQ-037 In mode 1, pulse one_flag and two_flag together -> ignored (two_flag wins, equal to current mode); no camera_rstn pulse; busy stays 0.
REQ-038 During a mode 0->1 sequence, pulse one_flag in SETTLE -> after DONE a second sequence runs with words 16'h5A40, 16'h5B34; final mode = 0.
REQ-039 Hold cfg_ack low for 50 cycles in CFG -> cfg_req and cfg_data stay stable; the sequence resumes on ack.
REQ-040 Assert rst_n low mid-CFG -> outputs take reset values immediately; no further cfg_req.
